// File: rtl/lights_out_pkg.sv
// Shared keypad/game constants and the press-detector state encoding.
// Pure declarations; no timing or flow-control behaviour.
package lights_out_pkg;
    localparam int NUM_KEYS = 9;
    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } press_state_e;

    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/lights_out_key_debounce.sv
// Frame-level debouncer: keys_stable follows a snapshot seen DEBOUNCE_FRAMES times in a row.
// Latency: keys_stable updates one cycle after the qualifying snapshot; no backpressure, ena freezes.
module lights_out_key_debounce
    import lights_out_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                frame_vld,
    input  logic [NUM_KEYS-1:0] frame_dat,
    output logic [NUM_KEYS-1:0] keys_stable
);
    localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic [NUM_KEYS-1:0] snap;
    logic [CNT_W-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap        <= '0;
            cnt         <= '0;
            keys_stable <= '0;
        end else if (ena) begin
            if (frame_vld) begin
                snap <= frame_dat;
                if (frame_dat == snap) begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                end
            end
            // Saturated counter means snap has matched DEBOUNCE_FRAMES snapshots in a row.
            if ((cnt == CNT_MAX) && (snap != keys_stable))
                keys_stable <= snap;
        end
    end
endmodule

// File: rtl/lights_out_keypad_scanner.sv
// 3x3 keypad column scanner with debounce and single-key press pulse for the game core.
// Latency: btn pulses 2 cycles after the qualifying snapshot edge; no backpressure, ena freezes.
module lights_out_keypad_scanner
    import lights_out_pkg::*;
#(
    parameter int COL_CYCLES      = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_sel,
    output logic [NUM_KEYS-1:0] btn,
    output logic [NUM_KEYS-1:0] keys_stable
);
    localparam int DW_W = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(COL_CYCLES - 1);

    logic [DW_W-1:0]     dwell;
    logic                dwell_end;
    logic [NUM_KEYS-1:0] raw;
    logic                frame_vld;
    logic [NUM_KEYS-1:0] frame_dat;
    press_state_e        state, state_nxt;
    logic [NUM_KEYS-1:0] btn_q, btn_nxt;

    assign dwell_end = (dwell == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_sel <= NUM_COLS'(1);
            dwell   <= '0;
            raw     <= '0;
        end else if (ena) begin
            if (dwell_end) begin
                dwell   <= '0;
                col_sel <= {col_sel[NUM_COLS-2:0], col_sel[NUM_COLS-1]};
                for (int r = 0; r < NUM_ROWS; r++)
                    for (int c = 0; c < NUM_COLS; c++)
                        if (col_sel[c])
                            raw[r*NUM_COLS + c] <= row_in[r];
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // The snapshot must include the last column, which is captured on this same edge.
    always_comb begin
        frame_dat = raw;
        for (int r = 0; r < NUM_ROWS; r++)
            frame_dat[r*NUM_COLS + NUM_COLS-1] = row_in[r];
        frame_vld = ena && dwell_end && col_sel[NUM_COLS-1];
    end

    lights_out_key_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .frame_vld  (frame_vld),
        .frame_dat  (frame_dat),
        .keys_stable(keys_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARMED;
            btn_q <= '0;
        end else if (ena) begin
            state <= state_nxt;
            btn_q <= btn_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        btn_nxt   = '0;
        case (state)
            ARMED: begin
                if (keys_stable != '0) begin
                    state_nxt = LOCKED;
                    if (is_one_hot(keys_stable))
                        btn_nxt = keys_stable;
                end
            end
            LOCKED: begin
                if (keys_stable == '0)
                    state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    assign btn = ena ? btn_q : '0;
endmodule

// File: tb/tb_lights_out_keypad_scanner.sv
// Scoreboard bench: directed keypad scenarios push expected press pulses; a negedge monitor pops and checks them.
module tb_lights_out_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] row_in;
    logic [2:0] col_sel;
    logic [8:0] btn;
    logic [8:0] keys_stable;
    logic [8:0] keys = '0;

    typedef struct {
        logic [8:0] val;
        int         at;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_no = 0;
    logic mon_en = 1'b0;

    lights_out_keypad_scanner #(
        .COL_CYCLES(4),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .row_in     (row_in),
        .col_sel    (col_sel),
        .btn        (btn),
        .keys_stable(keys_stable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Physical keypad: a pressed key shorts its row to the driven column.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (col_sel[c] && keys[r*3 + c])
                    row_in[r] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, exp, edge_no);
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_no < n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [8:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && (btn !== 9'h000)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL btn_unexpected actual=%0h required=0 edge=%0d", btn, edge_no);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("btn_value", btn, e.val);
                chk("btn_edge", edge_no, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout edge=%0d", edge_no);
        $fatal(1);
    end

    initial begin
        int r0, b0, c0, d0, e0, rp;
        rst = 1'b1;
        ena = 1'b1;
        wait_edge(2);
        rst = 1'b0;
        mon_en = 1'b1;
        r0 = 2;
        chk("reset_btn", btn, 9'h000);
        chk("reset_keys", keys_stable, 9'h000);

        // Idle scan: 4 cycles per column, 200 cycles with nothing stable.
        for (int i = 0; i < 200; i++) begin
            wait_edge(r0 + i);
            if (i < 36)
                chk("idle_col_sel", col_sel, 3'b001 << ((i / 4) % 3));
            chk("idle_keys", keys_stable, 9'h000);
        end

        // Centre key held 5 frames.
        b0 = r0 + 204;
        wait_edge(b0);
        keys = 9'h010;
        expect_pulse(9'h010, b0 + 38);
        wait_edge(b0 + 36);
        chk("centre_before", keys_stable, 9'h000);
        wait_edge(b0 + 37);
        chk("centre_stable", keys_stable, 9'h010);
        wait_edge(b0 + 60);
        keys = 9'h000;
        wait_edge(b0 + 97);
        chk("centre_release", keys_stable, 9'h000);

        // One-frame glitch on centre key.
        c0 = b0 + 108;
        wait_edge(c0);
        keys = 9'h010;
        wait_edge(c0 + 12);
        keys = 9'h000;
        wait_edge(c0 + 14);
        chk("glitch_keys_a", keys_stable, 9'h000);
        wait_edge(c0 + 30);
        chk("glitch_keys_b", keys_stable, 9'h000);

        // Two keys together, partial release, full release, then a single key.
        d0 = c0 + 36;
        wait_edge(d0);
        keys = 9'h101;
        wait_edge(d0 + 37);
        chk("multi_stable", keys_stable, 9'h101);
        wait_edge(d0 + 60);
        keys = 9'h100;
        wait_edge(d0 + 96);
        chk("partial_before", keys_stable, 9'h101);
        wait_edge(d0 + 97);
        chk("partial_stable", keys_stable, 9'h100);
        wait_edge(d0 + 108);
        keys = 9'h000;
        wait_edge(d0 + 145);
        chk("multi_released", keys_stable, 9'h000);
        wait_edge(d0 + 156);
        keys = 9'h004;
        expect_pulse(9'h004, d0 + 194);
        wait_edge(d0 + 193);
        chk("key2_stable", keys_stable, 9'h004);
        wait_edge(d0 + 204);
        keys = 9'h000;

        // Reset mid-press with key held, then an enable freeze mid-column.
        e0 = d0 + 252;
        wait_edge(e0);
        keys = 9'h010;
        expect_pulse(9'h010, e0 + 38);
        wait_edge(e0 + 49);
        rst = 1'b1;
        wait_edge(e0 + 50);
        rst = 1'b0;
        rp = e0 + 50;
        chk("midreset_btn", btn, 9'h000);
        chk("midreset_keys", keys_stable, 9'h000);
        chk("midreset_col", col_sel, 3'b001);
        expect_pulse(9'h010, rp + 38);
        wait_edge(rp + 37);
        chk("redetect_keys", keys_stable, 9'h010);

        wait_edge(rp + 42);
        ena = 1'b0;
        for (int j = 42; j <= 62; j++) begin
            wait_edge(rp + j);
            chk("freeze_col", col_sel, 3'b010);
            chk("freeze_btn", btn, 9'h000);
            chk("freeze_keys", keys_stable, 9'h010);
        end
        ena = 1'b1;
        wait_edge(rp + 63);
        chk("resume_col_a", col_sel, 3'b010);
        wait_edge(rp + 64);
        chk("resume_col_b", col_sel, 3'b100);
        wait_edge(rp + 72);
        keys = 9'h000;
        wait_edge(rp + 130);
        chk("pending_pulses", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lights_out_keypad_scanner.md
LIGHTS_OUT_KEYPAD_SCANNER -- requirements
Module: lights_out_keypad_scanner

Interface
REQ-001 Parameter COL_CYCLES, default 4: clock cycles each column is driven; the rows are sampled on the last of them.
REQ-002 Parameter DEBOUNCE_FRAMES, default 3: number of consecutive identical frame snapshots needed to accept a new key state.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  one clock; reset is synchronous and active-high.
REQ-005 ena  input  1  design enable; low freezes all state and forces btn to zero.
REQ-006 row_in  input  3  row sense lines, active-high; bit r = row r.
REQ-007 col_sel  output  3  one-hot column drive, active-high; bit c = column c.
REQ-008 btn  output  9  one-hot single-cycle press pulse; bit (row*3+col), bit0 = top-left; drives the game's button vector directly.
REQ-009 keys_stable  output  9  current debounced key state, same bit mapping as btn.

Function
REQ-010 Scan SHALL rotate col_sel 001 -> 010 -> 100 -> 001, holding each value COL_CYCLES cycles; one frame = 3*COL_CYCLES cycles.
REQ-011 On the last dwell cycle of column c, row_in[r] SHALL be captured into raw bit (r*3+c); earlier dwell cycles are settling and SHALL be ignored.
REQ-012 At the edge that ends column 2's dwell, the 9-bit raw vector SHALL be loaded into the frame snapshot register.
REQ-013 Debounce counter: snapshot equal to previous snapshot -> increment, saturating at DEBOUNCE_FRAMES-1; unequal -> clear to 0.
REQ-014 When the counter reaches DEBOUNCE_FRAMES-1 and snapshot differs from keys_stable, keys_stable SHALL load snapshot on the next edge.
REQ-015 Press FSM states: ARMED (awaiting press) and LOCKED (key(s) held).
REQ-016 ARMED -> LOCKED when keys_stable becomes nonzero; if exactly one bit is set, btn SHALL equal keys_stable for exactly that one cycle.
REQ-017 Two or more bits stable in ARMED: transition to LOCKED, no pulse (multi-key rejected).
REQ-018 LOCKED -> ARMED only when keys_stable returns to all-zero; additional or changed keys while LOCKED SHALL never produce a pulse.
REQ-019 btn SHALL be zero in every cycle except those defined in REQ-016; at most one bit ever set.
REQ-020 Latency: btn pulse occurs exactly 2 cycles after the snapshot edge that satisfies REQ-014 (keys_stable update edge, then pulse cycle).
REQ-021 ena low: scan counter, column, snapshot, counter, FSM hold values; btn = 0; col_sel holds; scanning resumes from the held position when ena rises.
REQ-022 Glitch shorter than DEBOUNCE_FRAMES frames SHALL leave keys_stable and btn unchanged.

Reset
REQ-023 rst high at a clock edge: col_sel = 001, dwell counter = 0, raw = 0, snapshot = 0, debounce counter = 0, keys_stable = 0, btn = 0, FSM = ARMED.
REQ-024 rst SHALL take priority over ena; reset mid-press SHALL discard the press, and a still-held key SHALL be re-detected after DEBOUNCE_FRAMES full frames.

Structure
REQ-025 Package lights_out_pkg SHALL hold NUM_KEYS=9, NUM_ROWS=3, NUM_COLS=3, and the press-FSM state enum, shared with the game core.
REQ-026 One sub-module, lights_out_key_debounce (snapshot compare, saturating counter, keys_stable register), SHALL be instantiated; scan and press FSM stay in the top.

Verification (defaults: COL_CYCLES=4, DEBOUNCE_FRAMES=3, frame=12 cycles)
REQ-027 Reset, no keys: col_sel sequence 001x4, 010x4, 100x4 repeating; btn = 0 and keys_stable = 0 for 200 cycles.
REQ-028 Hold row1/col1 (centre) for 5 frames: keys_stable = 9'h010 after the third matching snapshot; btn = 9'h010 for exactly one cycle, 2 cycles after that snapshot edge.
REQ-029 Centre held 1 frame, then released: keys_stable stays 0, btn never asserts.
REQ-030 Hold keys 0 and 8 together 5 frames: keys_stable = 9'h101, no pulse; release 0 only: no pulse; release all 4 frames, then press key 2: btn = 9'h004 once.
REQ-031 Key 4 held, rst pulsed 1 cycle mid-frame: btn = 0 through reset; key 4 pulse recurs after 3 frames; ena low 20 cycles mid-scan: col_sel frozen, btn = 0, scan resumes at the same column.
